ct_window_accumulator: RTL and testbench
========================================

// Module: ct_window_accumulator
// PURPOSE
// - Downstream of the CT scaling multiplier: takes its 24-bit sign-magnitude product (out) and done strobe.
// - Accumulates a window of WINDOW samples and publishes per window:
//   - signed mean (DC offset)
//   - mean absolute value
//   - peak magnitude
//   - zero-crossing count (optional)
// - Results feed the power-quality decision logic.
// PARAMETERS
// - WINDOW  256  samples per window; power of two, >= 4
// - WIN_LG2 8    log2(WINDOW)
// - ACC_W   32   accumulator width; full range needs >= 24+WIN_LG2, smaller widths saturate
// PORTS
// - clk            in   1      system clock
// - rst_n          in   1      asynchronous active-low reset
// - run            in   1      1 = accumulate; 0 = abort window, return to idle
// - in_data        in   24     sign-magnitude sample: [23] sign, [22:0] magnitude
// - in_valid       in   1      one-cycle strobe, in_data valid (multiplier done)
// - mean_out       out  24     signed two's-complement window mean
// - mean_abs_out   out  23     mean of magnitudes
// - peak_out       out  23     largest magnitude in window
// - zc_out         out  16     zero crossings in window (ZERO_CROSS_EN only, else 0)
// - win_valid      out  1      one-cycle pulse, result outputs updated
// - ovf            out  1      sticky: accumulator saturated; cleared when run=0
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - all outputs 0; state S_IDLE
//   - sample counter, sum, abs-sum and peak cleared
// - States:
//   - S_IDLE: run=1 -> S_ACCUM; in_valid is ignored in S_IDLE.
//   - S_ACCUM, on in_valid:
//     - sum   += (sign ? -mag : +mag), sign-extended to ACC_W
//     - abs   += mag
//     - peak   = max(peak, mag)
//     - cnt   += 1
//     - sample with cnt==WINDOW-1 -> S_PUB
//   - S_PUB, exactly one cycle:
//     - mean_out = sum>>>WIN_LG2 (arithmetic shift, truncate toward -inf)
//     - mean_abs_out = abs>>WIN_LG2
//     - peak_out = peak
//     - win_valid=1
//     - sum/abs/peak/cnt cleared; next state S_ACCUM
// - Latency: win_valid asserts the cycle after the last sample's in_valid.
// - Results hold until the next S_PUB.
// - in_valid during S_PUB: the sample is sample 0 of the next window and is not lost.
//   Accumulators load that sample's terms instead of clearing.
// - run=0 in any state: next cycle S_IDLE.
//   - Partial window discarded; no win_valid.
//   - ovf cleared; result outputs keep their last published values.
// - Negative zero (sign=1, mag=0) is treated as +0 everywhere.
// - Saturation: sum clamps to the ACC_W signed max/min and abs clamps to the unsigned max.
//   Either clamp sets ovf.
// - in_valid never arrives closer than 1 cycle apart.
//   The block still accepts back-to-back in_valid at full rate.
// CONFIGURATION
// - ZERO_CROSS_EN defined:
//   - Track the sign of the last nonzero sample in the window.
//   - Each nonzero sample whose sign differs from it increments zc (saturates at 16'hFFFF).
//   - Zero samples never count and do not update the tracked sign.
//   - zc_out is published in S_PUB; zc and tracked sign are cleared at window start.
// - ZERO_CROSS_EN undefined: no zc logic; zc_out tied to 16'h0000.
// TESTING (WINDOW=4, WIN_LG2=4->2, ACC_W=32 unless noted)
// - Reset mid-window: run=1, 2 samples, rst_n=0 -> all outputs 0, no win_valid; 4 new samples give a clean window.
// - Signed mean: samples +100,+100,-40,+0 (24'h000064,24'h000064,24'h800028,24'h000000)
//   -> mean_out=24'h000028, mean_abs_out=60, peak_out=100, win_valid one cycle.
// - Negative mean/truncation: -1,-1,-1,-2 -> mean_out=24'hFFFFFE (-5>>>2 = -2), mean_abs_out=1.
// - Back-to-back: 5 in_valid on consecutive cycles, 5th coinciding with S_PUB -> window 2 contains sample 5 (cnt=1).
// - Abort: run=0 after 3 samples, run=1, 4 samples of +8 -> single win_valid, mean_out=8.
// - Saturation (ACC_W=24): 4 x +23'h7FFFFF -> ovf=1, mean_out=24'h1FFFFF (clamped sum 24'h7FFFFF >>> 2).
// - ZERO_CROSS_EN: +5,0,-5,+5 -> zc_out=2; -0,+3,+3,-3 -> zc_out=1.

Source files
------------

// File: rtl/ct_window_accumulator.sv
// ct_window_accumulator: accumulates WINDOW sign-magnitude samples from the
// CT scaling multiplier. Once per window it publishes the signed mean, the
// mean magnitude and the peak magnitude. When the ZERO_CROSS_EN macro is
// defined, it also publishes a zero-crossing count; otherwise zc_out is
// tied to zero.
module ct_window_accumulator #(
  parameter int WINDOW  = 256,
  parameter int WIN_LG2 = 8,
  parameter int ACC_W   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [23:0] in_data,
  input  logic        in_valid,
  output logic [23:0] mean_out,
  output logic [22:0] mean_abs_out,
  output logic [22:0] peak_out,
  output logic [15:0] zc_out,
  output logic        win_valid,
  output logic        ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_PUB} state_t;

  state_t             state, state_nxt;
  logic [WIN_LG2-1:0] cnt;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   abs_acc;
  logic [22:0]        peak;

  logic [22:0]        mag;
  logic               neg;
  logic               take;
  logic               restart;
  logic               last;
  logic [23:0]        term;
  logic [ACC_W-1:0]   base_sum;
  logic [ACC_W-1:0]   base_abs;
  logic [22:0]        base_peak;
  logic [WIN_LG2-1:0] base_cnt;
  logic [ACC_W:0]     sum_wide;
  logic [ACC_W:0]     abs_wide;
  logic               sum_ovf;
  logic               abs_ovf;
  logic [ACC_W-1:0]   sum_new;
  logic [ACC_W-1:0]   abs_new;
  logic [22:0]        peak_new;
  logic [WIN_LG2-1:0] cnt_new;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: run=0 always wins and returns to idle
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = run ? S_ACCUM : S_IDLE;
      S_ACCUM: if (!run)     state_nxt = S_IDLE;
               else if (last) state_nxt = S_PUB;
      S_PUB:   state_nxt = run ? S_ACCUM : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sample datapath. In S_PUB the accumulators restart from zero, so a
  // sample arriving in that cycle becomes sample 0 of the next window.
  always_comb begin
    mag       = in_data[22:0];
    neg       = in_data[23] & (|mag);
    take      = run & in_valid & (state != S_IDLE);
    restart   = (state == S_PUB);
    last      = take & (state == S_ACCUM) & (cnt == WIN_LG2'(WINDOW - 1));
    term      = neg ? (24'd0 - {1'b0, mag}) : {1'b0, mag};
    base_sum  = restart ? '0 : sum;
    base_abs  = restart ? '0 : abs_acc;
    base_peak = restart ? '0 : peak;
    base_cnt  = restart ? '0 : cnt;
    sum_wide  = {base_sum[ACC_W-1], base_sum} + {{(ACC_W-23){term[23]}}, term};
    abs_wide  = {1'b0, base_abs} + {{(ACC_W-22){1'b0}}, mag};
    sum_ovf   = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    abs_ovf   = abs_wide[ACC_W];
    if (!sum_ovf)             sum_new = sum_wide[ACC_W-1:0];
    else if (sum_wide[ACC_W]) sum_new = {1'b1, {(ACC_W-1){1'b0}}};
    else                      sum_new = {1'b0, {(ACC_W-1){1'b1}}};
    abs_new   = abs_ovf ? '1 : abs_wide[ACC_W-1:0];
    peak_new  = (mag > base_peak) ? mag : base_peak;
    cnt_new   = base_cnt + WIN_LG2'(1);
  end

  // Accumulators, sticky overflow and result registers. Results load on
  // the last sample's edge, so they are present during the S_PUB cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      sum          <= '0;
      abs_acc      <= '0;
      peak         <= '0;
      ovf          <= 1'b0;
      win_valid    <= 1'b0;
      mean_out     <= '0;
      mean_abs_out <= '0;
      peak_out     <= '0;
    end else begin
      win_valid <= 1'b0;
      if (!run) begin
        cnt     <= '0;
        sum     <= '0;
        abs_acc <= '0;
        peak    <= '0;
        ovf     <= 1'b0;
      end else if (take) begin
        cnt     <= cnt_new;
        sum     <= sum_new;
        abs_acc <= abs_new;
        peak    <= peak_new;
        if (sum_ovf || abs_ovf) ovf <= 1'b1;
        if (last) begin
          mean_out     <= 24'($signed(sum_new) >>> WIN_LG2);
          mean_abs_out <= 23'(abs_new >> WIN_LG2);
          peak_out     <= peak_new;
          win_valid    <= 1'b1;
        end
      end else if (restart) begin
        cnt     <= '0;
        sum     <= '0;
        abs_acc <= '0;
        peak    <= '0;
      end
    end
  end

`ifdef ZERO_CROSS_EN
  logic [15:0] zc;
  logic        zc_seen;
  logic        zc_neg;
  logic [15:0] base_zc;
  logic        base_seen;
  logic        base_neg;
  logic        zc_hit;

  // Crossing detect against the sign of the last nonzero sample
  always_comb begin
    base_zc   = restart ? '0 : zc;
    base_seen = restart ? 1'b0 : zc_seen;
    base_neg  = restart ? 1'b0 : zc_neg;
    zc_hit    = (|mag) & base_seen & (neg != base_neg) & (base_zc != '1);
  end

  // Zero-crossing counter and tracked sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zc      <= '0;
      zc_seen <= 1'b0;
      zc_neg  <= 1'b0;
      zc_out  <= '0;
    end else if (!run) begin
      zc      <= '0;
      zc_seen <= 1'b0;
      zc_neg  <= 1'b0;
    end else if (take) begin
      zc <= base_zc + {15'd0, zc_hit};
      if (|mag) begin
        zc_seen <= 1'b1;
        zc_neg  <= neg;
      end else begin
        zc_seen <= base_seen;
        zc_neg  <= base_neg;
      end
      if (last) zc_out <= base_zc + {15'd0, zc_hit};
    end else if (restart) begin
      zc      <= '0;
      zc_seen <= 1'b0;
      zc_neg  <= 1'b0;
    end
  end
`else
  assign zc_out = 16'h0000;
`endif

endmodule

// File: tb/tb_ct_window_accumulator.sv
// Scoreboard bench for ct_window_accumulator: stimulus pushes expected
// window results, a monitor pops them on each win_valid pulse.
module tb_ct_window_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, in_valid;
  logic [23:0] in_data;
  logic [23:0] mean_out;
  logic [22:0] mean_abs_out, peak_out;
  logic [15:0] zc_out;
  logic        win_valid, ovf;

  logic        run_s, in_valid_s;
  logic [23:0] in_data_s;
  logic [23:0] mean_out_s;
  logic [22:0] mean_abs_out_s, peak_out_s;
  logic [15:0] zc_out_s;
  logic        win_valid_s, ovf_s;

  always #5 clk = ~clk;

  ct_window_accumulator #(.WINDOW(4), .WIN_LG2(2), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .in_data(in_data), .in_valid(in_valid),
    .mean_out(mean_out), .mean_abs_out(mean_abs_out), .peak_out(peak_out),
    .zc_out(zc_out), .win_valid(win_valid), .ovf(ovf));

  ct_window_accumulator #(.WINDOW(4), .WIN_LG2(2), .ACC_W(24)) dut_sat (
    .clk(clk), .rst_n(rst_n), .run(run_s), .in_data(in_data_s), .in_valid(in_valid_s),
    .mean_out(mean_out_s), .mean_abs_out(mean_abs_out_s), .peak_out(peak_out_s),
    .zc_out(zc_out_s), .win_valid(win_valid_s), .ovf(ovf_s));

  typedef struct {
    logic [23:0] mean;
    logic [22:0] mabs;
    logic [22:0] peak;
    logic [15:0] zc;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q_main[$];
  exp_t q_sat[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] zc_exp(input int v);
`ifdef ZERO_CROSS_EN
    return 16'(v);
`else
    return 16'(v * 0);
`endif
  endfunction

  // Monitor: compare each published window against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (win_valid) begin
        if (q_main.size() == 0) check("main_unexpected_win_valid", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q_main.pop_front();
          check("main_latency", cyc, e.cyc);
          check("main_mean", {8'd0, mean_out}, {8'd0, e.mean});
          check("main_mean_abs", {9'd0, mean_abs_out}, {9'd0, e.mabs});
          check("main_peak", {9'd0, peak_out}, {9'd0, e.peak});
          check("main_zc", {16'd0, zc_out}, {16'd0, e.zc});
          check("main_ovf", {31'd0, ovf}, {31'd0, e.ovf});
        end
      end
      if (win_valid_s) begin
        if (q_sat.size() == 0) check("sat_unexpected_win_valid", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q_sat.pop_front();
          check("sat_latency", cyc, e.cyc);
          check("sat_mean", {8'd0, mean_out_s}, {8'd0, e.mean});
          check("sat_mean_abs", {9'd0, mean_abs_out_s}, {9'd0, e.mabs});
          check("sat_peak", {9'd0, peak_out_s}, {9'd0, e.peak});
          check("sat_zc", {16'd0, zc_out_s}, {16'd0, e.zc});
          check("sat_ovf", {31'd0, ovf_s}, {31'd0, e.ovf});
        end
      end
    end
  end

  task automatic put(input bit s, input logic [23:0] d);
    @(posedge clk); #1;
    if (s) begin in_valid_s = 1'b1; in_data_s = d; end
    else   begin in_valid   = 1'b1; in_data   = d; end
  endtask

  task automatic gap();
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_valid_s = 1'b0;
  endtask

  // Call right after the last sample is driven: it is captured on the next
  // edge, and win_valid must be seen at the negedge that follows.
  task automatic expect_win(input bit s, input logic [23:0] m, input logic [22:0] a,
                            input logic [22:0] p, input logic [15:0] z, input logic o);
    exp_t e;
    e.mean = m; e.mabs = a; e.peak = p; e.zc = z; e.ovf = o; e.cyc = cyc + 1;
    if (s) q_sat.push_back(e);
    else   q_main.push_back(e);
  endtask

  task automatic send4(input bit s, input logic [23:0] d0, input logic [23:0] d1,
                       input logic [23:0] d2, input logic [23:0] d3,
                       input logic [23:0] m, input logic [22:0] a, input logic [22:0] p,
                       input logic [15:0] z, input logic o);
    put(s, d0); gap();
    put(s, d1); gap();
    put(s, d2); gap();
    put(s, d3);
    expect_win(s, m, a, p, z, o);
    gap();
  endtask

  task automatic check_main_zero(input string tag);
    check({tag, "_mean"}, {8'd0, mean_out}, 32'd0);
    check({tag, "_mean_abs"}, {9'd0, mean_abs_out}, 32'd0);
    check({tag, "_peak"}, {9'd0, peak_out}, 32'd0);
    check({tag, "_zc"}, {16'd0, zc_out}, 32'd0);
    check({tag, "_win_valid"}, {31'd0, win_valid}, 32'd0);
    check({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; in_valid = 1'b0; in_data = '0;
    run_s = 1'b0; in_valid_s = 1'b0; in_data_s = '0;
    #2;
    check_main_zero("reset");
    #10 rst_n = 1'b1;

    // run rises with a sample present: state is still S_IDLE, sample ignored
    @(posedge clk); #1;
    run = 1'b1; in_valid = 1'b1; in_data = 24'h000200;

    // Signed mean with a zero sample: sum 160 -> 40
    send4(1'b0, 24'h000064, 24'h000064, 24'h800028, 24'h000000,
          24'h000028, 23'd60, 23'd100, zc_exp(1), 1'b0);
    // Negative mean truncates toward -inf: -5 >>> 2 = -2
    send4(1'b0, 24'h800001, 24'h800001, 24'h800001, 24'h800002,
          24'hFFFFFE, 23'd1, 23'd2, zc_exp(0), 1'b0);

    // Reset mid-window after two samples
    put(1'b0, 24'h000007); gap();
    put(1'b0, 24'h000009); gap();
    rst_n = 1'b0;
    #1;
    check_main_zero("midreset");
    @(negedge clk); rst_n = 1'b1;
    gap();
    send4(1'b0, 24'h000001, 24'h000002, 24'h000003, 24'h000004,
          24'h000002, 23'd2, 23'd4, zc_exp(0), 1'b0);

    // Back-to-back: fifth sample lands in S_PUB and opens window 2
    put(1'b0, 24'd10); put(1'b0, 24'd20); put(1'b0, 24'd30); put(1'b0, 24'd40);
    expect_win(1'b0, 24'd25, 23'd25, 23'd40, zc_exp(0), 1'b0);
    put(1'b0, 24'h800004); put(1'b0, 24'd8); put(1'b0, 24'd8); put(1'b0, 24'd12);
    expect_win(1'b0, 24'd6, 23'd8, 23'd12, zc_exp(1), 1'b0);
    gap();

    // Abort after three samples; last results must be retained
    put(1'b0, 24'd100); gap();
    put(1'b0, 24'd100); gap();
    put(1'b0, 24'd100); gap();
    run = 1'b0;
    gap(); gap();
    check("abort_mean_hold", {8'd0, mean_out}, 32'd6);
    check("abort_peak_hold", {9'd0, peak_out}, 32'd12);
    run = 1'b1;
    gap();
    send4(1'b0, 24'd8, 24'd8, 24'd8, 24'd8, 24'd8, 23'd8, 23'd8, zc_exp(0), 1'b0);

    // Zero-crossing patterns (zero and negative-zero samples)
    send4(1'b0, 24'h000005, 24'h000000, 24'h800005, 24'h000005,
          24'd1, 23'd3, 23'd5, zc_exp(2), 1'b0);
    send4(1'b0, 24'h800000, 24'h000003, 24'h000003, 24'h800003,
          24'd0, 23'd2, 23'd3, zc_exp(1), 1'b0);
    run = 1'b0;
    gap();

    // Saturation on the ACC_W=24 instance
    run_s = 1'b1;
    gap();
    send4(1'b1, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF,
          24'h1FFFFF, 23'h3FFFFF, 23'h7FFFFF, zc_exp(0), 1'b1);
    gap();
    check("sat_ovf_sticky", {31'd0, ovf_s}, 32'd1);
    run_s = 1'b0;
    gap(); gap();
    check("sat_ovf_cleared", {31'd0, ovf_s}, 32'd0);
    check("sat_mean_hold", {8'd0, mean_out_s}, 32'h001FFFFF);

    repeat (4) gap();
    check("main_pending_windows", q_main.size(), 32'd0);
    check("sat_pending_windows", q_sat.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
